// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
// Shared bus types and constants for the instruction fetch slice.
//   AddrBus  : 32-bit byte address
//   InstBus  : 32-bit instruction word
//   Enable / Disable / ZeroWord : common control and data constants
//   pcIncrement() : next sequential PC, 32-bit modulo
// ---------------------------------------------------------------------------
package if_fetch_pkg;

   localparam int ADDR_W = 32;
   localparam int INST_W = 32;

   typedef logic [ADDR_W-1:0] AddrBus;
   typedef logic [INST_W-1:0] InstBus;

   localparam logic   Enable   = 1'b1;
   localparam logic   Disable  = 1'b0;
   localparam InstBus ZeroWord = '0;

   // Sequential PC step; the add is deliberately left to wrap at 2^32
   function automatic AddrBus pcIncrement(input AddrBus pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_fetch_icache.sv
// ---------------------------------------------------------------------------
// icache
// Direct-mapped instruction cache with one-word lines.
//   clk, rst   : clock and synchronous active-high reset (clears valid bits)
//   i_rdIdx    : lookup index          i_rdTag  : lookup tag
//   o_hit      : line valid and tag matches   o_data : line data
//   i_wrEn     : fill strobe           i_wrIdx / i_wrTag / i_wrData : fill line
// Lookup is combinational so the fetch unit can decide and present in the
// same cycle.
// ---------------------------------------------------------------------------
module icache
   import if_fetch_pkg::*;
#(
   parameter int IDX_W = 6,
   parameter int TAG_W = ADDR_W - IDX_W - 2
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] i_rdIdx,
   input  logic [TAG_W-1:0] i_rdTag,
   output logic             o_hit,
   output InstBus           o_data,
   input  logic             i_wrEn,
   input  logic [IDX_W-1:0] i_wrIdx,
   input  logic [TAG_W-1:0] i_wrTag,
   input  InstBus           i_wrData
);

   localparam int DEPTH = 1 << IDX_W;

   logic [DEPTH-1:0] r_valid;
   logic [TAG_W-1:0] r_tag  [DEPTH];
   InstBus           r_data [DEPTH];

   // Valid bits are the only state that needs clearing; a line whose valid
   // bit is low never reports a hit, so tag and data can power up as garbage.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
      end else if (i_wrEn) begin
         r_valid[i_wrIdx] <= 1'b1;
      end
   end

   // Tag and data storage, written only by a completed fill.
   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         r_tag[i_wrIdx]  <= i_wrTag;
         r_data[i_wrIdx] <= i_wrData;
      end
   end

   assign o_hit  = r_valid[i_rdIdx] && (r_tag[i_rdIdx] == i_rdTag);
   assign o_data = r_data[i_rdIdx];

endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction fetch unit: holds the PC, looks it up in a direct-mapped
// icache, requests missing words from the memory controller's IF port and
// hands one instruction per cycle to decode.
//   clk, rst       : clock, synchronous active-high reset
//   rdy            : global ready; all state holds while low
//   if_enable      : fetch request to memory controller
//   if_addr        : word address being fetched
//   if_inst        : fetched word, valid while if_finished is high
//   if_finished    : one-cycle completion pulse from the controller
//   jump_en        : redirect request (highest priority)
//   jump_addr      : redirect target
//   id_stall       : decode cannot accept an instruction this cycle
//   inst_valid     : inst_o / pc_o carry a valid instruction
//   inst_o, pc_o   : instruction and its address
// ---------------------------------------------------------------------------
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter AddrBus RESET_PC     = 32'h0,
   parameter int     ICACHE_IDX_W = 6
)
(
   input  logic   clk,
   input  logic   rst,
   input  logic   rdy,
   output logic   if_enable,
   output AddrBus if_addr,
   input  InstBus if_inst,
   input  logic   if_finished,
   input  logic   jump_en,
   input  AddrBus jump_addr,
   input  logic   id_stall,
   output logic   inst_valid,
   output InstBus inst_o,
   output AddrBus pc_o
);

   localparam int TAG_W = ADDR_W - ICACHE_IDX_W - 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MISS  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0] r_state;
   AddrBus     r_pc;

   logic       w_hit;
   InstBus     w_data;
   logic       w_fill;
   logic       w_slotFree;

   // The output slot can take a new instruction when it is empty or when
   // decode is consuming the current one this very cycle.
   assign w_slotFree = !inst_valid || !id_stall;

   // A fill lands in the cache whenever the outstanding request completes,
   // even if a redirect arrived meanwhile: the word is still correct for
   // if_addr, it just is not presented.
   assign w_fill = rdy && !rst && (r_state == ST_MISS) && if_finished;

   icache #(
      .IDX_W (ICACHE_IDX_W),
      .TAG_W (TAG_W)
   ) u_icache (
      .clk      (clk),
      .rst      (rst),
      .i_rdIdx  (r_pc[ICACHE_IDX_W+1:2]),
      .i_rdTag  (r_pc[ADDR_W-1:ICACHE_IDX_W+2]),
      .o_hit    (w_hit),
      .o_data   (w_data),
      .i_wrEn   (w_fill),
      .i_wrIdx  (if_addr[ICACHE_IDX_W+1:2]),
      .i_wrTag  (if_addr[ADDR_W-1:ICACHE_IDX_W+2]),
      .i_wrData (if_inst)
   );

   // Fetch FSM, PC and output register. IDLE presents hits straight from the
   // cache; a miss parks in MISS with a stable request until the controller
   // completes, then DRAIN spends one cycle with if_enable low so the
   // controller can reset its byte counter. The refilled line is then found
   // by the ordinary IDLE lookup, which keeps a single presentation path.
   // A redirect is applied last so it overrides anything the state did to
   // the PC or the output slot, but it never cancels an outstanding request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_pc       <= RESET_PC;
         if_enable  <= Disable;
         if_addr    <= '0;
         inst_valid <= Disable;
         inst_o     <= ZeroWord;
         pc_o       <= '0;
      end else if (rdy) begin
         if (inst_valid && !id_stall) begin
            inst_valid <= Disable;
         end
         case (r_state)
            ST_IDLE: begin
               if (!jump_en && w_slotFree) begin
                  if (w_hit) begin
                     inst_valid <= Enable;
                     inst_o     <= w_data;
                     pc_o       <= r_pc;
                     r_pc       <= pcIncrement(r_pc);
                  end else begin
                     if_enable <= Enable;
                     if_addr   <= r_pc;
                     r_state   <= ST_MISS;
                  end
               end
            end
            ST_MISS: begin
               if (if_finished) begin
                  if_enable <= Disable;
                  r_state   <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
         if (jump_en) begin
            r_pc       <= jump_addr;
            inst_valid <= Disable;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
// Drives if_fetch against a simple memory responder and checks it against a
// transaction-level model: the stream of presented (pc, inst) pairs, the
// addresses requested on a miss, request stability and hold behaviour.
// ---------------------------------------------------------------------------
module tb_if_fetch;

   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        if_enable;
   logic [31:0] if_addr;
   logic [31:0] if_inst;
   logic        if_finished;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic        id_stall;
   logic        inst_valid;
   logic [31:0] inst_o;
   logic [31:0] pc_o;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model: which words are cached, the next PC expected at the
   // decoder, and the address of the outstanding request.
   logic        modelValid [64];
   logic [23:0] modelTag   [64];
   logic [31:0] modelPc;
   logic [31:0] reqAddr;
   int          idleCycles;

   // Inputs/outputs as they stood at the most recent clock edge
   logic        prevRst, prevRdy, prevStall, prevJump;
   logic        prevValid, prevEn, prevFinished;
   logic [31:0] prevPc, prevInst, prevAddr;

   // Memory responder
   int          memDelay    = 5;
   int          memCnt      = 0;
   logic        lateFinish  = 1'b0;

   if_fetch #(
      .RESET_PC     (RESET_PC),
      .ICACHE_IDX_W (6)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .if_enable   (if_enable),
      .if_addr     (if_addr),
      .if_inst     (if_inst),
      .if_finished (if_finished),
      .jump_en     (jump_en),
      .jump_addr   (jump_addr),
      .id_stall    (id_stall),
      .inst_valid  (inst_valid),
      .inst_o      (inst_o),
      .pc_o        (pc_o)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Backstop in case a bounded loop is ever mis-sized
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: observed no finish, expected finish");
      $fatal(1);
   end

   function automatic logic [31:0] memFn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   function automatic logic modelHit(input logic [31:0] a);
      return modelValid[a[7:2]] && (modelTag[a[7:2]] == a[31:8]);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 64; i++) begin
         modelValid[i] = 1'b0;
         modelTag[i]   = '0;
      end
      modelPc    = RESET_PC;
      reqAddr    = '0;
      idleCycles = 0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkFlag(input string tag, input logic obs, input logic exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   // Compare DUT outputs after an edge against what the model expects from
   // the inputs that were applied for that edge.
   task automatic observeCycle();
      logic presented;
      presented = 1'b0;
      if (prevRst) begin
         checkFlag("rst_en", if_enable, 1'b0);
         checkOutput("rst_addr", if_addr, 32'h0);
         checkFlag("rst_valid", inst_valid, 1'b0);
         checkOutput("rst_inst", inst_o, 32'h0);
         checkOutput("rst_pc", pc_o, 32'h0);
         modelReset();
      end else if (!prevRdy) begin
         checkFlag("hold_rdy_en", if_enable, prevEn);
         checkOutput("hold_rdy_addr", if_addr, prevAddr);
         checkFlag("hold_rdy_valid", inst_valid, prevValid);
         checkOutput("hold_rdy_pc", pc_o, prevPc);
         checkOutput("hold_rdy_inst", inst_o, prevInst);
      end else begin
         if (prevEn && prevFinished) begin
            modelValid[reqAddr[7:2]] = 1'b1;
            modelTag[reqAddr[7:2]]   = reqAddr[31:8];
            checkFlag("en_drop", if_enable, 1'b0);
         end else if (prevEn) begin
            checkFlag("en_hold", if_enable, 1'b1);
            checkOutput("addr_hold", if_addr, reqAddr);
         end else if (if_enable) begin
            checkOutput("miss_addr", if_addr, modelPc);
            checkFlag("miss_real", modelHit(if_addr), 1'b0);
            reqAddr = modelPc;
         end
         if (prevJump) begin
            checkFlag("jump_flush", inst_valid, 1'b0);
         end else if (prevValid && prevStall) begin
            checkFlag("stall_valid", inst_valid, 1'b1);
            checkOutput("stall_pc", pc_o, prevPc);
            checkOutput("stall_inst", inst_o, prevInst);
         end else if (inst_valid) begin
            checkOutput("present_pc", pc_o, modelPc);
            checkOutput("present_inst", inst_o, memFn(modelPc));
            checkFlag("present_hit", modelHit(modelPc), 1'b1);
            modelPc   = modelPc + 32'd4;
            presented = 1'b1;
         end
         if (presented || inst_valid) begin
            idleCycles = 0;
         end else begin
            idleCycles++;
            if (idleCycles > 80) begin
               checkOutput("watchdog", 32'(idleCycles), 32'd0);
               idleCycles = 0;
            end
         end
      end
   endtask

   // Drive inputs for the next edge and advance the memory responder.
   task automatic applyStimulus(input logic rstv, input logic rdyv, input logic stall,
                                input logic jmp, input logic [31:0] jaddr);
      prevValid = inst_valid;
      prevPc    = pc_o;
      prevInst  = inst_o;
      prevEn    = if_enable;
      prevAddr  = if_addr;
      if (rstv) begin
         if_finished = 1'b0;
         memCnt      = 0;
      end else if (lateFinish) begin
         if_finished = 1'b1;
         if_inst     = 32'hDEAD_BEEF;
         memCnt      = 0;
         lateFinish  = 1'b0;
      end else if (if_finished) begin
         if (prevRdy) begin
            if_finished = 1'b0;
            memCnt      = 0;
         end
      end else if (if_enable) begin
         memCnt++;
         if (memCnt >= memDelay) begin
            if_finished = 1'b1;
            if_inst     = memFn(if_addr);
         end
      end else begin
         memCnt = 0;
      end
      prevFinished = if_finished;
      prevRst      = rstv;
      prevRdy      = rdyv;
      prevStall    = stall;
      prevJump     = jmp && rdyv && !rstv;
      if (prevJump) begin
         modelPc = jaddr;
      end
      rst       = rstv;
      rdy       = rdyv;
      id_stall  = stall;
      jump_en   = jmp;
      jump_addr = jaddr;
   endtask

   task automatic step(input logic rstv, input logic rdyv, input logic stall,
                       input logic jmp, input logic [31:0] jaddr);
      @(negedge clk);
      observeCycle();
      applyStimulus(rstv, rdyv, stall, jmp, jaddr);
   endtask

   task automatic idleStep();
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic waitValid(input string tag);
      int n;
      n = 0;
      while (!inst_valid && n < 80) begin
         idleStep();
         n++;
      end
      checkFlag(tag, inst_valid, 1'b1);
   endtask

   task automatic waitRequest(input string tag, input logic [31:0] addr);
      int n;
      n = 0;
      while (!(if_enable && if_addr == addr) && n < 80) begin
         idleStep();
         n++;
      end
      checkFlag(tag, if_enable, 1'b1);
      checkOutput({tag, "_addr"}, if_addr, addr);
   endtask

   initial begin
      int lat;
      int hi;
      int n;
      logic [31:0] ja;

      // Reset held through the first edge
      rst = 1'b1; rdy = 1'b1; id_stall = 1'b0; jump_en = 1'b0;
      jump_addr = '0; if_finished = 1'b0; if_inst = '0;
      prevRst = 1'b1; prevRdy = 1'b1; prevStall = 1'b0; prevJump = 1'b0;
      prevValid = 1'b0; prevEn = 1'b0; prevFinished = 1'b0;
      prevPc = '0; prevInst = '0; prevAddr = '0;
      modelReset();
      idleStep();

      // Cold start: miss at 0, then fill, drain, hit
      waitRequest("cold_req", 32'h0);
      lat = 0;
      while (!inst_valid && lat < 40) begin
         idleStep();
         lat++;
      end
      checkOutput("cold_latency", 32'(lat), 32'd7);
      checkOutput("cold_inst", inst_o, 32'h13);
      checkOutput("cold_pc", pc_o, 32'h0);
      waitRequest("cold_next", 32'h4);

      // Run up to 12, then redirect while the miss at 0x10 is outstanding
      n = 0;
      while (!(inst_valid && pc_o == 32'hC) && n < 80) begin
         idleStep();
         n++;
      end
      checkOutput("reach_12", pc_o, 32'hC);
      waitRequest("miss16", 32'h10);
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
      waitValid("redir_valid");
      checkOutput("redir_pc", pc_o, 32'h40);

      // Warm loop: 0..16 all cached, one per cycle, no requests
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      waitValid("warm_valid");
      for (int k = 0; k < 5; k++) begin
         checkOutput("warm_pc", pc_o, 32'(k * 4));
         checkFlag("warm_en", if_enable, 1'b0);
         checkFlag("warm_seq_valid", inst_valid, 1'b1);
         idleStep();
      end

      // Stall three edges while holding the instruction at 8
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      waitValid("stall_first");
      idleStep();
      checkOutput("stall_pre", pc_o, 32'h4);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, (k < 3), 1'b0, 32'h0);
         checkOutput("stall_held", pc_o, 32'h8);
         checkFlag("stall_held_valid", inst_valid, 1'b1);
      end
      idleStep();
      checkOutput("stall_release", pc_o, 32'hC);

      // Memory contention: long completion, request must stay constant
      memDelay = 12;
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
      waitRequest("cont_req", 32'h200);
      hi = 0;
      while (if_enable && hi < 40) begin
         hi++;
         idleStep();
      end
      checkOutput("cont_len", 32'(hi), 32'd12);
      memDelay = 5;
      waitValid("cont_valid");
      checkOutput("cont_pc", pc_o, 32'h200);

      // Reset in the middle of a miss, followed by a stray completion
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h300);
      waitRequest("rst_miss", 32'h300);
      idleStep();
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      lateFinish = 1'b1;
      idleStep();
      waitRequest("rst_refetch", RESET_PC);
      waitValid("rst_valid");
      checkOutput("rst_refetch_pc", pc_o, RESET_PC);
      checkOutput("rst_refetch_inst", inst_o, 32'h13);

      // PC wrap at the top of the address space
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      waitValid("wrap_a");
      checkOutput("wrap_top", pc_o, 32'hFFFF_FFFC);
      idleStep();
      waitValid("wrap_b");
      checkOutput("wrap_zero", pc_o, 32'h0);

      // Random traffic: stalls, redirects, ready gaps, rare resets
      for (int i = 0; i < 3000; i++) begin
         ja = 32'($urandom_range(0, 127)) << 2;
         step(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), ja);
      end
      idleStep();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
